// File: rtl/alu_serial_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer and its 1-bit slice.
package alu_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_LESS = 2'b11;

   // ctrl_i = {invertA, invertB, aluOp[1:0]}
   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b0110;
   localparam logic [3:0] CTRL_SLT = 4'b0111;
   localparam logic [3:0] CTRL_NOR = 4'b1100;

endpackage

// File: rtl/alu_slice_1b.sv
// Combinational 1-bit ALU slice: and/or/add/less with operand inversion,
// plus the set and overflow outputs that are only meaningful on the MSB.
module alu_slice_1b
   import alu_serial_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       invertA,
   input  logic       invertB,
   input  logic [1:0] aluOp,
   input  logic       carryIn,
   input  logic       less,
   output logic       result,
   output logic       carryOut,
   output logic       set,
   output logic       overflow
);

   logic a_s;
   logic b_s;
   logic sum_s;

   // Operand conditioning, full adder and result selection
   always_comb begin
      a_s      = a ^ invertA;
      b_s      = b ^ invertB;
      sum_s    = a_s ^ b_s ^ carryIn;
      carryOut = (a_s & b_s) | (a_s & carryIn) | (b_s & carryIn);
      overflow = carryIn ^ carryOut;
      // On overflow the true sign is the inverse of the sum, which equals carryOut
      set      = overflow ? carryOut : sum_s;
      case (aluOp)
         OP_AND:  result = a_s & b_s;
         OP_OR:   result = a_s | b_s;
         OP_ADD:  result = sum_s;
         OP_LESS: result = less;
         default: result = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: runs one 1-bit slice over a W-bit operand, LSB first,
// owning the carry chain register and the set-less-than feedback into bit 0.
module alu_serial_seq
   import alu_serial_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [W-1:0] src1_i,
   input  logic [W-1:0] src2_i,
   input  logic [3:0]   ctrl_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] result_o,
   output logic         zero_o,
   output logic         cout_o,
   output logic         overflow_o
);

   localparam int               CNT_W    = $clog2(W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

   state_e           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             carry_r;
   logic [W-1:0]     opa_r;
   logic [W-1:0]     opb_r;
   logic [3:0]       ctrl_r;
   logic [W-1:0]     res_r;
   logic             set_r;
   logic             cout_r;
   logic             ovf_r;
   logic             busy_r;
   logic             done_r;

   logic             slice_res_s;
   logic             slice_cout_s;
   logic             slice_set_s;
   logic             slice_ovf_s;

   alu_slice_1b u_slice (
      .a        (opa_r[0]),
      .b        (opb_r[0]),
      .invertA  (ctrl_r[3]),
      .invertB  (ctrl_r[2]),
      .aluOp    (ctrl_r[1:0]),
      .carryIn  (carry_r),
      .less     (1'b0),
      .result   (slice_res_s),
      .carryOut (slice_cout_s),
      .set      (slice_set_s),
      .overflow (slice_ovf_s)
   );

   // Sequencer state, operand/result shift registers and flag capture
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         carry_r <= 1'b0;
         opa_r   <= '0;
         opb_r   <= '0;
         ctrl_r  <= 4'b0000;
         res_r   <= '0;
         set_r   <= 1'b0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  opa_r   <= src1_i;
                  opb_r   <= src2_i;
                  ctrl_r  <= ctrl_i;
                  carry_r <= ctrl_i[2];
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               res_r   <= {slice_res_s, res_r[W-1:1]};
               opa_r   <= {1'b0, opa_r[W-1:1]};
               opb_r   <= {1'b0, opb_r[W-1:1]};
               carry_r <= slice_cout_s;
               if (cnt_r == LAST_CNT) begin
                  cout_r <= ctrl_r[1] ? slice_cout_s : 1'b0;
                  ovf_r  <= ctrl_r[1] ? slice_ovf_s : 1'b0;
                  set_r  <= slice_set_s;
                  if (ctrl_r[1:0] == OP_LESS) begin
                     state_r <= ST_FIX;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_FIX: begin
               res_r[0] <= set_r;
               state_r  <= ST_IDLE;
               busy_r   <= 1'b0;
               done_r   <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o     = busy_r;
   assign done_o     = done_r;
   assign result_o   = res_r;
   assign zero_o     = (res_r == '0);
   assign cout_o     = cout_r;
   assign overflow_o = ovf_r;

endmodule
